ct_mmu_iutlb_refill_ctrl: RTL
=============================

// Module: ct_mmu_iutlb_refill_ctrl
// PURPOSE
// Sequences the iuTLB entry array: detects misses, requests the jTLB, writes refills into the first entry and
// swaps the displaced first entry into a victim entry. Aggregates per-entry hit/valid, one refill in flight.
// Sits between IFU lookup, jTLB and the entry instances.
// PARAMETERS
// ENTRY_NUM  16  total entries incl. first entry (index 0); >=2
// IDX_W      $clog2(ENTRY_NUM)  entry index width
// VPN_WIDTH  27  virtual page number width
// PORTS
// utlb_entry_clk    in   1          gated uTLB clock
// cpurst_b          in   1          async reset, active-low
// ifu_mmu_va_vld    in   1          lookup request valid
// ifu_mmu_vpn       in   VPN_WIDTH  lookup VPN
// utlb_entry_vld    in   ENTRY_NUM  per-entry valid
// utlb_entry_hit    in   ENTRY_NUM  per-entry VPN/page-size match
// tlb_flush         in   1          regs/tlboper global or VA clear, any form
// mmu_jtlb_req      out  1          refill request, held until grant
// mmu_jtlb_vpn      out  VPN_WIDTH  captured miss VPN
// jtlb_mmu_grant    in   1          jTLB accepted request
// jtlb_mmu_cmplt    in   1          refill data valid (1 cycle)
// jtlb_mmu_fault    in   1          qualifies cmplt: page fault, no PTE
// utlb_hit          out  1          lookup hit: |(vld & hit) & va_vld
// utlb_hit_idx      out  IDX_W      lowest hit index
// utlb_refill_busy  out  1          FSM not IDLE (IFU stalls)
// utlb_entry_upd    out  ENTRY_NUM  update strobe; only bit0 ever set
// utlb_entry_swp    out  ENTRY_NUM  one-hot swap strobe into victim; bit0 never set
// utlb_entry_swp_on out  1          payload valid for swap = entry0 valid
// mmu_ifu_pgflt     out  1          1-cycle fault pulse
// utlb_miss_cnt     out  16         miss counter (IUTLB_MISS_CNT_EN only)
// BEHAVIOUR
// - Reset cpurst_b, asynchronous, active-low; clock utlb_entry_clk.
// - Reset: state=IDLE, all outputs 0, rr_ptr=1, captured vpn=0, counter=0.
// - FSM IDLE->REQ on va_vld & ~utlb_hit; vpn captured same edge. Lookups while busy ignored.
// - REQ: mmu_jtlb_req=1; ->WAIT on grant. Grant and cmplt same cycle -> straight to UPD/IDLE per fault.
// - WAIT: cmplt & ~fault -> UPD; cmplt & fault -> IDLE + mmu_ifu_pgflt pulse next cycle.
// - UPD (1 cycle): upd[0]=1; swp[victim]=1; swp_on=utlb_entry_vld[0]; ->IDLE. Refill latency = grant-to-cmplt + 2.
// - Victim: lowest-index invalid entry in 1..ENTRY_NUM-1; else rr_ptr.
// - rr_ptr advances only when a valid entry is overwritten; wraps ENTRY_NUM-1 -> 1, never 0.
// - tlb_flush in REQ/WAIT: ->IDLE, drop any later/concurrent cmplt, no upd/swp.
// - tlb_flush in UPD: strobes suppressed that cycle (clear has priority).
// - Outstanding jTLB response after abort is ignored: the cmplt counts only in WAIT/REQ.
// - Combinational hit path has no state; utlb_hit_idx=0 when no hit.
// CONFIGURATION
// - IUTLB_MISS_CNT_EN defined: utlb_miss_cnt increments by 1 on each IDLE->REQ, saturates at 16'hFFFF, cleared only by reset.
// - Undefined: counter absent, utlb_miss_cnt tied 0.
// STRUCTURE
// - Package ct_mmu_iutlb_pkg: state enum {IDLE,REQ,WAIT,UPD} (2b), VPN_WIDTH/PPN_WIDTH/FLG_WIDTH/PGS_WIDTH constants.
// - Sub-module ct_mmu_iutlb_victim_sel: vld vector + rr_ptr -> victim one-hot/idx (combinational priority find).
// TESTING
// - Miss on vpn=27'h12345, all invalid: req 1 until grant; cmplt -> upd[0]=1, swp[1]=1, swp_on=0; busy low after.
// - All 16 valid, rr_ptr=15, miss+refill: swp[15]=1, swp_on=1, rr_ptr wraps to 1.
// - tlb_flush asserted in WAIT, cmplt next cycle: no upd/swp, state IDLE, no pgflt.
// - cmplt with fault=1: pgflt pulses 1 cycle, no upd/swp.
// - grant and cmplt same cycle: UPD next cycle; reset mid-WAIT: all outputs 0 immediately.
// - With IUTLB_MISS_CNT_EN, 3 misses -> cnt=3; preload 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/ct_mmu_iutlb_pkg.sv
// Shared types and field widths for the iuTLB refill control slice.
package ct_mmu_iutlb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    UPD  = 2'd3
  } state_e;

  localparam int VPN_WIDTH = 27;
  localparam int PPN_WIDTH = 28;
  localparam int FLG_WIDTH = 14;
  localparam int PGS_WIDTH = 3;

endpackage

// File: rtl/ct_mmu_iutlb_victim_sel.sv
// Victim picker: lowest-index invalid entry among 1..ENTRY_NUM-1, otherwise the round-robin pointer.
module ct_mmu_iutlb_victim_sel
  import ct_mmu_iutlb_pkg::*;
#(
  parameter int ENTRY_NUM = 16,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:1] vld,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [ENTRY_NUM-1:0] victim_oh,
  output logic                 victim_is_rr
);

  logic [IDX_W-1:0] victim_idx;

  // Scan downwards so the lowest invalid index is the last one written.
  always_comb begin
    victim_idx   = rr_ptr;
    victim_is_rr = 1'b1;
    for (int i = ENTRY_NUM - 1; i >= 1; i--) begin
      if (!vld[i]) begin
        victim_idx   = IDX_W'(i);
        victim_is_rr = 1'b0;
      end
    end
  end

  always_comb begin
    victim_oh             = '0;
    victim_oh[victim_idx] = 1'b1;
  end

endmodule

// File: rtl/ct_mmu_iutlb_refill_ctrl.sv
// iuTLB refill sequencer: miss detect, jTLB request, refill into entry 0 and swap into a victim.
// Optional miss counter enabled by defining IUTLB_MISS_CNT_EN.
module ct_mmu_iutlb_refill_ctrl
  import ct_mmu_iutlb_pkg::*;
#(
  parameter int ENTRY_NUM = 16,
  parameter int IDX_W     = $clog2(ENTRY_NUM),
  parameter int VPN_WIDTH = 27
) (
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 ifu_mmu_va_vld,
  input  logic [VPN_WIDTH-1:0] ifu_mmu_vpn,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  input  logic [ENTRY_NUM-1:0] utlb_entry_hit,
  input  logic                 tlb_flush,
  output logic                 mmu_jtlb_req,
  output logic [VPN_WIDTH-1:0] mmu_jtlb_vpn,
  input  logic                 jtlb_mmu_grant,
  input  logic                 jtlb_mmu_cmplt,
  input  logic                 jtlb_mmu_fault,
  output logic                 utlb_hit,
  output logic [IDX_W-1:0]     utlb_hit_idx,
  output logic                 utlb_refill_busy,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [ENTRY_NUM-1:0] utlb_entry_swp,
  output logic                 utlb_entry_swp_on,
  output logic                 mmu_ifu_pgflt,
  output logic [15:0]          utlb_miss_cnt
);

  state_e                 state;
  state_e                 next_state;
  logic [ENTRY_NUM-1:0]   hit_vec;
  logic [IDX_W-1:0]       rr_ptr;
  logic [ENTRY_NUM-1:0]   victim_oh;
  logic                   victim_is_rr;
  logic [VPN_WIDTH-1:0]   vpn_q;
  logic                   pgflt_q;
  logic                   miss_start;
  logic                   rsp_vld;
  logic                   upd_fire;

  assign hit_vec  = utlb_entry_vld & utlb_entry_hit & {ENTRY_NUM{ifu_mmu_va_vld}};
  assign utlb_hit = |hit_vec;

  always_comb begin
    utlb_hit_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) utlb_hit_idx = IDX_W'(i);
    end
  end

  // A response is only honoured for the live request; flush drops it outright.
  assign miss_start = (state == IDLE) & ifu_mmu_va_vld & ~utlb_hit;
  assign rsp_vld    = jtlb_mmu_cmplt & ~tlb_flush &
                      ((state == WAIT) | ((state == REQ) & jtlb_mmu_grant));
  assign upd_fire   = (state == UPD) & ~tlb_flush;

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (miss_start) next_state = REQ;
      REQ: begin
        if (tlb_flush)           next_state = IDLE;
        else if (jtlb_mmu_grant) begin
          if (!jtlb_mmu_cmplt)     next_state = WAIT;
          else if (jtlb_mmu_fault) next_state = IDLE;
          else                     next_state = UPD;
        end
      end
      WAIT: begin
        if (tlb_flush)           next_state = IDLE;
        else if (jtlb_mmu_cmplt) next_state = jtlb_mmu_fault ? IDLE : UPD;
      end
      UPD:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mmu_jtlb_req      = 1'b0;
    utlb_refill_busy  = 1'b0;
    utlb_entry_upd    = '0;
    utlb_entry_swp    = '0;
    utlb_entry_swp_on = 1'b0;
    case (state)
      REQ: begin
        mmu_jtlb_req     = 1'b1;
        utlb_refill_busy = 1'b1;
      end
      WAIT: utlb_refill_busy = 1'b1;
      UPD: begin
        utlb_refill_busy = 1'b1;
        if (upd_fire) begin
          utlb_entry_upd[0] = 1'b1;
          utlb_entry_swp    = victim_oh;
          utlb_entry_swp_on = utlb_entry_vld[0];
        end
      end
      default: ;
    endcase
  end

  ct_mmu_iutlb_victim_sel #(
    .ENTRY_NUM (ENTRY_NUM),
    .IDX_W     (IDX_W)
  ) u_victim_sel (
    .vld          (utlb_entry_vld[ENTRY_NUM-1:1]),
    .rr_ptr       (rr_ptr),
    .victim_oh    (victim_oh),
    .victim_is_rr (victim_is_rr)
  );

  // Round-robin pointer only moves when a live entry is evicted; entry 0 is never a victim.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr <= IDX_W'(1);
    end else if (upd_fire && victim_is_rr) begin
      rr_ptr <= (rr_ptr == IDX_W'(ENTRY_NUM - 1)) ? IDX_W'(1) : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vpn_q   <= '0;
      pgflt_q <= 1'b0;
    end else begin
      pgflt_q <= rsp_vld & jtlb_mmu_fault;
      if (miss_start) vpn_q <= ifu_mmu_vpn;
    end
  end

  assign mmu_jtlb_vpn  = vpn_q;
  assign mmu_ifu_pgflt = pgflt_q;

`ifdef IUTLB_MISS_CNT_EN
  logic [15:0] miss_cnt;

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      miss_cnt <= '0;
    end else if (miss_start && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign utlb_miss_cnt = miss_cnt;
`else
  assign utlb_miss_cnt = 16'h0;
`endif

endmodule
